// File: rtl/fft_stream_driver.sv
// Host-side frame driver for the 64-point FFT: buffers a host frame, streams it to the FFT as
// one start-qualified burst, captures the result frame and hands it back over a valid/ready port.
module fft_stream_driver #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_in,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] fft_in_stream,
    output logic              fft_data_start,
    output logic              fft_mode,
    input  logic [DATA_W-1:0] fft_out_stream,
    input  logic              fft_data_out,
    input  logic              fft_next_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_LEN);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {StLoad, StSend, StWait, StDrain} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] tx_buf [FRAME_LEN];
    logic [DATA_W-1:0] rx_buf [FRAME_LEN];

    logic [CNT_W-1:0]  wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0]  tx_idx_q, tx_idx_d;
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
    logic [CNT_W-1:0]  rd_idx_q, rd_idx_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W-1:0] stream_q, stream_d;
    logic              start_q, start_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              tx_we, rx_we;

    // The FFT last-word flag is informational; completion is tracked by cap_cnt.
    logic unused_next_data;
    assign unused_next_data = fft_next_data;

    assign wr_ready       = (state_q == StLoad) && !rst;
    assign busy           = (state_q != StLoad);
    assign rd_valid       = (state_q == StDrain);
    assign rd_data        = rx_buf[rd_idx_q[IDX_W-1:0]];
    assign fft_in_stream  = stream_q;
    assign fft_data_start = start_q;
    assign fft_mode       = mode_q;
    assign frame_done     = done_q;
    assign timeout_err    = err_q;

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        tx_idx_d  = tx_idx_q;
        cap_cnt_d = cap_cnt_q;
        rd_idx_d  = rd_idx_q;
        tmo_cnt_d = '0;
        stream_d  = stream_q;
        start_d   = 1'b0;
        mode_d    = mode_q;
        done_d    = 1'b0;
        err_d     = err_q;
        tx_we     = 1'b0;
        rx_we     = 1'b0;

        // Results may start arriving while the burst is still going out.
        if ((state_q == StSend || state_q == StWait) && fft_data_out && cap_cnt_q < FULL_CNT) begin
            rx_we     = 1'b1;
            cap_cnt_d = cap_cnt_q + 1'b1;
        end

        unique case (state_q)
            StLoad: begin
                if (wr_valid && wr_ready) begin
                    tx_we    = 1'b1;
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        mode_d   = mode_in;
                        stream_d = tx_buf[0];
                        start_d  = 1'b1;
                        tx_idx_d = CNT_W'(1);
                        state_d  = StSend;
                    end
                end
            end
            StSend: begin
                if (tx_idx_q == FULL_CNT) begin
                    stream_d = '0;
                    state_d  = StWait;
                end else begin
                    stream_d = tx_buf[tx_idx_q[IDX_W-1:0]];
                    tx_idx_d = tx_idx_q + 1'b1;
                end
            end
            StWait: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (cap_cnt_d == FULL_CNT) begin
                    state_d = StDrain;
                end else if (tmo_cnt_d == TMO_LIMIT) begin
                    err_d     = 1'b1;
                    wr_idx_d  = '0;
                    tx_idx_d  = '0;
                    cap_cnt_d = '0;
                    rd_idx_d  = '0;
                    tmo_cnt_d = '0;
                    state_d   = StLoad;
                end
            end
            StDrain: begin
                if (rd_ready) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == LAST_IDX) begin
                        done_d    = 1'b1;
                        wr_idx_d  = '0;
                        tx_idx_d  = '0;
                        cap_cnt_d = '0;
                        rd_idx_d  = '0;
                        state_d   = StLoad;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StLoad;
            wr_idx_q  <= '0;
            tx_idx_q  <= '0;
            cap_cnt_q <= '0;
            rd_idx_q  <= '0;
            tmo_cnt_q <= '0;
            stream_q  <= '0;
            start_q   <= 1'b0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            tx_idx_q  <= tx_idx_d;
            cap_cnt_q <= cap_cnt_d;
            rd_idx_q  <= rd_idx_d;
            tmo_cnt_q <= tmo_cnt_d;
            stream_q  <= stream_d;
            start_q   <= start_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Buffers are not reset; each frame fully overwrites them.
    always_ff @(posedge clk) begin
        if (tx_we) begin
            tx_buf[wr_idx_q[IDX_W-1:0]] <= wr_data;
        end
        if (rx_we && !rst) begin
            rx_buf[cap_cnt_q[IDX_W-1:0]] <= fft_out_stream;
        end
    end

endmodule

// File: tb/tb_fft_stream_driver.sv
// Bench for fft_stream_driver: behavioural FFT model (x+5 after a set latency), scoreboards for
// the outbound burst and the returned results, a scenario table and hand-written corner cases.
`timescale 1ns/1ps
module tb_fft_stream_driver;

    localparam int FRAME_LEN = 64;
    localparam int TIMEOUT   = 1023;
    localparam int OFFSET    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_in = 1'b0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_ready;
    logic [31:0] fft_in_stream;
    logic        fft_data_start;
    logic        fft_mode;
    logic [31:0] fft_out_stream = '0;
    logic        fft_data_out = 1'b0;
    logic        fft_next_data = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_ready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    fft_stream_driver dut (
        .clk            (clk),
        .rst            (rst),
        .mode_in        (mode_in),
        .wr_valid       (wr_valid),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .fft_in_stream  (fft_in_stream),
        .fft_data_start (fft_data_start),
        .fft_mode       (fft_mode),
        .fft_out_stream (fft_out_stream),
        .fft_data_out   (fft_data_out),
        .fft_next_data  (fft_next_data),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_ready       (rd_ready),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] val;
    } fft_item_t;

    typedef struct {
        logic [31:0] base;
        bit          toggle;
        int          lat;
        int          stall_at;
        int          stall_len;
        bit          mode;
        bit          mode_after;
        bit          poke;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        bit          exp_mode;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] exp_tx[$];
    logic [31:0] exp_rd[$];
    fft_item_t   fft_q[$];
    int          fft_lat = 15;
    bit          fft_en = 1'b1;
    bit          burst_active = 1'b0;
    int          burst_pos = 0;
    bit          check_zero = 1'b0;
    int          wait_entry = 0;
    int          last_acc_cyc = -10;
    int          last_cap_cyc = -10;
    int          rd_count = 0;
    int          done_due = -10;
    logic [31:0] first_rd, last_rd;
    bit          acc;
    bit          rdy_s, busy_s, rdv_s, start_s, mode_s, done_s, err_s;
    logic [31:0] rdd_s, stream_s;
    vec_t        tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Sample the current cycle mid-period, then advance and drive the FFT model outputs.
    task automatic step();
        fft_item_t it;
        @(negedge clk);
        rdy_s = wr_ready; busy_s = busy; rdv_s = rd_valid; rdd_s = rd_data;
        start_s = fft_data_start; mode_s = fft_mode; done_s = frame_done;
        err_s = timeout_err; stream_s = fft_in_stream;
        acc = wr_valid && wr_ready;
        if (acc) begin
            exp_tx.push_back(wr_data);
            exp_rd.push_back(wr_data + 32'(OFFSET));
        end
        if (check_zero) begin
            check("wait_stream_zero", stream_s, 0);
            check("wait_busy", 32'(busy_s), 1);
            check_zero = 1'b0;
        end
        if (start_s) begin
            check("start_cycle", cyc, last_acc_cyc + 1);
            burst_active = 1'b1;
            burst_pos = 0;
        end
        if (burst_active) begin
            if (exp_tx.size() == 0) fail_now("tx_underflow");
            else check("tx_word", stream_s, exp_tx.pop_front());
            if (fft_en) fft_q.push_back('{cyc + fft_lat, stream_s + 32'(OFFSET)});
            burst_pos++;
            if (burst_pos == FRAME_LEN) begin
                burst_active = 1'b0;
                check_zero = 1'b1;
                wait_entry = cyc + 1;
            end
        end
        if (rdv_s && rd_ready) begin
            if (exp_rd.size() == 0) fail_now("rd_underflow");
            else check("rd_word", rdd_s, exp_rd.pop_front());
            if (rd_count == 0) first_rd = rdd_s;
            last_rd = rdd_s;
            rd_count++;
            if (rd_count == FRAME_LEN) done_due = cyc + 1;
        end
        if (done_s || cyc == done_due) check("frame_done", 32'(done_s), 32'(cyc == done_due));
        @(posedge clk);
        #1;
        cyc++;
        if (fft_q.size() > 0 && fft_q[0].due == cyc) begin
            it = fft_q.pop_front();
            fft_data_out = 1'b1;
            fft_out_stream = it.val;
            if (fft_q.size() == 0) last_cap_cyc = cyc;
        end else begin
            fft_data_out = 1'b0;
            fft_out_stream = $urandom;
        end
        fft_next_data = fft_data_out && (fft_q.size() == 0);
    endtask

    task automatic load_frame(input logic [31:0] base, input bit toggle);
        int k = 0;
        int budget = 400;
        while (k < FRAME_LEN && budget > 0) begin
            wr_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            wr_data = base + 32'(k);
            step();
            budget--;
            check("wr_ready_load", 32'(rdy_s), 1);
            if (acc) begin
                k++;
                if (k == FRAME_LEN) last_acc_cyc = cyc - 1;
            end
        end
        wr_valid = 1'b0;
        if (k < FRAME_LEN) fail_now("load_frame");
    endtask

    task automatic run_frame(input vec_t v);
        int  budget;
        bit  stalled = 1'b0;
        fft_lat = v.lat;
        fft_en = 1'b1;
        rd_ready = 1'b0;
        rd_count = 0;
        mode_in = v.mode;
        load_frame(v.base, v.toggle);
        mode_in = v.mode_after;
        if (v.poke) begin
            wr_valid = 1'b1;
            wr_data = 32'hDEAD_BEEF;
        end
        budget = 400;
        do begin
            step();
            budget--;
            if (v.poke && burst_active) check("wr_ready_send", 32'(rdy_s), 0);
        end while (!rdv_s && budget > 0);
        wr_valid = 1'b0;
        if (!rdv_s) begin
            fail_now("wait_rd_valid");
            return;
        end
        check("rd_valid_latency", cyc - 1, last_cap_cyc + 1);
        check("fft_mode_drain", 32'(mode_s), 32'(v.exp_mode));
        rd_ready = 1'b1;
        budget = 400;
        while (rd_count < FRAME_LEN && budget > 0) begin
            if (!stalled && v.stall_len > 0 && rd_count == v.stall_at) begin
                rd_ready = 1'b0;
                for (int i = 0; i < v.stall_len; i++) begin
                    step();
                    check("stall_rd_data", rdd_s, v.base + 32'(v.stall_at + OFFSET));
                    check("stall_rd_valid", 32'(rdv_s), 1);
                end
                rd_ready = 1'b1;
                stalled = 1'b1;
            end
            step();
            budget--;
        end
        rd_ready = 1'b0;
        if (rd_count < FRAME_LEN) fail_now("drain");
        step();
        check("load_after_done", 32'(rdy_s), 1);
        check("idle_after_done", 32'(busy_s), 0);
        check("first_rd", first_rd, v.exp_first);
        check("last_rd", last_rd, v.exp_last);
        check("rd_queue_empty", exp_rd.size(), 0);
    endtask

    initial begin
        int budget;
        int err_cyc;
        //          base  tgl lat stall len mode after poke first last  mode
        tbl[0] = '{32'd0,   0, 15,  0,   0,  0,   0,    0,  5,    68,   0};
        tbl[1] = '{32'd100, 1, 15,  0,   0,  0,   0,    0,  105,  168,  0};
        tbl[2] = '{32'd200, 0, 1,   30,  20, 1,   0,    1,  205,  268,  1};
        tbl[3] = '{32'd500, 1, 40,  63,  5,  1,   1,    1,  505,  568,  1};

        rst = 1'b1;
        step();
        check("rst_wr_ready", 32'(rdy_s), 0);
        check("rst_busy", 32'(busy_s), 0);
        check("rst_start", 32'(start_s), 0);
        check("rst_stream", stream_s, 0);
        check("rst_rd_valid", 32'(rdv_s), 0);
        check("rst_timeout_err", 32'(err_s), 0);
        rst = 1'b0;
        step();
        check("post_rst_wr_ready", 32'(rdy_s), 1);
        check("post_rst_mode", 32'(mode_s), 0);

        for (int i = 0; i < 4; i++) run_frame(tbl[i]);

        // FFT silent: abort after TIMEOUT cycles in WAIT.
        fft_en = 1'b0;
        load_frame(32'd300, 1'b0);
        budget = TIMEOUT + 200;
        do begin
            step();
            budget--;
        end while (!err_s && budget > 0);
        if (!err_s) begin
            fail_now("timeout_wait");
        end else begin
            err_cyc = cyc - 1;
            check("timeout_cycle", err_cyc, wait_entry + TIMEOUT);
            check("timeout_idle", 32'(busy_s), 0);
            check("timeout_wr_ready", 32'(rdy_s), 1);
            check("timeout_rd_valid", 32'(rdv_s), 0);
        end
        exp_rd.delete();
        step();
        check("timeout_sticky", 32'(err_s), 1);
        fft_en = 1'b1;

        // Reset in the middle of the burst, with the FFT model reset too.
        mode_in = 1'b1;
        load_frame(32'd400, 1'b0);
        budget = 100;
        while ((!burst_active || burst_pos < 20) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) fail_now("reset_wait");
        rst = 1'b1;
        burst_active = 1'b0;
        check_zero = 1'b0;
        exp_tx.delete();
        exp_rd.delete();
        fft_q.delete();
        fft_data_out = 1'b0;
        step();
        check("midrst_wr_ready", 32'(rdy_s), 0);
        rst = 1'b0;
        step();
        check("midrst_stream", stream_s, 0);
        check("midrst_start", 32'(start_s), 0);
        check("midrst_mode", 32'(mode_s), 0);
        check("midrst_rd_valid", 32'(rdv_s), 0);
        check("midrst_busy", 32'(busy_s), 0);
        check("midrst_done", 32'(done_s), 0);
        check("midrst_timeout_err", 32'(err_s), 0);
        check("midrst_wr_ready_after", 32'(rdy_s), 1);
        run_frame(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
